// File: rtl/gray_to_excess3_seq_pkg.sv
// Shared constants for the Gray -> XS-3 converter: FSM encodings, XS-3 offset,
// double-dabble adjust threshold and the per-digit adjust helper.
package gray_to_excess3_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] XS3_OFFSET     = 4'd3;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

  // Pre-shift correction so a digit that would reach >=10 carries into the next digit.
  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= BCD_ADJ_THRESH) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/gray_to_excess3_seq_if.sv
// Handshake bundle for gray_to_excess3_seq: gray word in, XS-3 digits out.
// GRAY2EX3_BCD_OUT_EN adds the raw BCD result alongside ex3.
interface gray_to_excess3_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      gray;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIGITS*4-1:0]   ex3;
  logic                  ovf;
`ifdef GRAY2EX3_BCD_OUT_EN
  logic [DIGITS*4-1:0]   bcd;

  modport master (output in_valid, gray, out_ready,
                  input  in_ready, out_valid, ex3, ovf, bcd);
  modport slave  (input  in_valid, gray, out_ready,
                  output in_ready, out_valid, ex3, ovf, bcd);
`else
  modport master (output in_valid, gray, out_ready,
                  input  in_ready, out_valid, ex3, ovf);
  modport slave  (input  in_valid, gray, out_ready,
                  output in_ready, out_valid, ex3, ovf);
`endif
endinterface

// File: rtl/gray_to_excess3_seq_gray_to_bin_n.sv
// Combinational N-bit Gray to binary decode (inverse of bin_to_gray_n).
// Latency 0; no handshake.
module gray_to_bin_n #(
  parameter int N = 16
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  // bin[i] is the XOR of all gray bits at or above i; avoids a rippling self-reference.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/gray_to_excess3_seq.sv
// Gray -> packed Excess-3 decimal converter, one double-dabble bit per clock.
// Latency BIN_W cycles from accept to out_valid; in_ready only in IDLE, result held until out_ready.
// Optional GRAY2EX3_BCD_OUT_EN exposes the raw BCD register on bus.bcd.
module gray_to_excess3_seq
  import gray_to_excess3_seq_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_to_excess3_seq_if.slave bus
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = ($clog2(BIN_W) > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W - 1);

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;

  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic [BIN_W-1:0]  bin_in;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_shift;
  logic [BIN_W-1:0]  bin_shift;
  logic              carry;
  logic [BCD_W-1:0]  ex3_w;

  gray_to_bin_n #(.N(BIN_W)) u_g2b (
    .gray (bus.gray),
    .bin  (bin_in)
  );

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign bcd_adj[4*d +: 4] = dabble_adj(bcd_q[4*d +: 4]);
    assign ex3_w[4*d +: 4]   = bcd_q[4*d +: 4] + XS3_OFFSET;
  end

  // Whatever leaves the top digit is lost decimal weight, so it feeds the sticky overflow.
  assign {carry, bcd_shift, bin_shift} = {bcd_adj, bin_q, 1'b0};

  assign accept = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      bin_q <= bin_in;
      bcd_q <= '0;
      cnt_q <= CNT_INIT;
      ovf_q <= 1'b0;
    end else if (state_q == ST_SHIFT) begin
      bin_q <= bin_shift;
      bcd_q <= bcd_shift;
      ovf_q <= ovf_q | carry;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.ex3       = ex3_w;
  assign bus.ovf       = ovf_q;
`ifdef GRAY2EX3_BCD_OUT_EN
  assign bus.bcd       = bcd_q;
`endif

endmodule
